lsu_dmem_if: RTL

Load/store interface unit between the pipeline MEM stage and the word-addressed data memory. It decodes RV32I load/store width from funct3, byte-aligns and sign/zero-extends load data, and performs byte/halfword stores as a two-cycle read-modify-write, stalling the pipeline for one cycle. The data memory has a combinational read port and a synchronous write port; this block drives both.

---
 rtl/lsu_dmem_if.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lsu_dmem_if.sv
// RV32I load/store unit: load align/extend, SW direct write, SB/SH as a stalled read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN flags misaligned half/word accesses and suppresses them.
module lsu_dmem_if #(
  parameter int DATA  = 32,
  parameter int ADDR  = 32,
  parameter int WADDR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [ADDR-1:0]  addr,
  input  logic [DATA-1:0]  wdata,
  output logic [DATA-1:0]  rdata,
  output logic             stall,
  output logic             misaligned,
  output logic [WADDR-1:0] dm_ra,
  input  logic [DATA-1:0]  dm_rd,
  output logic [WADDR-1:0] dm_wa,
  output logic [DATA-1:0]  dm_wd,
  output logic             dm_we
);

  typedef enum logic {IDLE, RMW} state_e;

  state_e           state_q, state_d;
  logic [WADDR-1:0] addr_q;
  logic [3:0]       be_q;
  logic [DATA-1:0]  data_q, old_q;

  logic [1:0] off;
  logic       f_b, f_h, f_w, f_bu, f_hu;
  logic       mis, sbsh_req, sw_req;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [3:0]  be_d;
  logic [DATA-1:0] rep_d, merged;
  logic        unused;

  assign unused = ^addr[ADDR-1:WADDR+2];
  assign dm_ra  = addr[WADDR+1:2];
  assign off    = addr[1:0];

  assign f_b  = (funct3 == 3'b000);
  assign f_h  = (funct3 == 3'b001);
  assign f_w  = (funct3 == 3'b010);
  assign f_bu = (funct3 == 3'b100);
  assign f_hu = (funct3 == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ~rst & ((mem_read  & (((f_h | f_hu) & off[0]) | (f_w & (off != 2'b00)))) |
                       (mem_write & ((f_h & off[0])          | (f_w & (off != 2'b00)))));
`else
  assign mis = 1'b0;
`endif
  assign misaligned = mis;

  assign sbsh_req = mem_write & (f_b | f_h) & ~mis;
  assign sw_req   = mem_write & f_w & ~mis;

  // Halfword selection uses off[1] only, so unaligned halfwords fall back to the aligned one.
  assign ld_b = dm_rd[{off, 3'b000} +: 8];
  assign ld_h = off[1] ? dm_rd[31:16] : dm_rd[15:0];

  always_comb begin
    rdata = '0;
    if (mem_read && !rst && !mis) begin
      if (f_b)       rdata = {{24{ld_b[7]}}, ld_b};
      else if (f_bu) rdata = {24'd0, ld_b};
      else if (f_h)  rdata = {{16{ld_h[15]}}, ld_h};
      else if (f_hu) rdata = {16'd0, ld_h};
      else if (f_w)  rdata = dm_rd;
    end
  end

  always_comb begin
    be_d  = f_b ? (4'b0001 << off) : (4'b0011 << {off[1], 1'b0});
    rep_d = f_b ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
  end

  always_comb begin
    merged = old_q;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sbsh_req) state_d = RMW;
      RMW:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = ~rst & (state_q == IDLE) & sbsh_req;
  assign dm_we = ~rst & ((state_q == RMW) | ((state_q == IDLE) & sw_req));
  assign dm_wa = (state_q == RMW) ? addr_q : dm_ra;
  assign dm_wd = (state_q == RMW) ? merged : wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sbsh_req) begin
        addr_q <= dm_ra;
        be_q   <= be_d;
        data_q <= rep_d;
        old_q  <= dm_rd;
      end
    end
  end

endmodule
